// File: rtl/mm_arb_pkg.sv
// Shared types and sizing helpers for the Montgomery-multiplier job arbiter.
// Pure declarations: no latency, no flow control.
package mm_arb_pkg;

  localparam int RUN_CNT_W = 32;
  localparam int DATA_W    = 17;

  typedef enum logic [2:0] {
    IDLE,
    HOST_LOAD,
    START,
    RUN,
    HOST_READ
  } arb_state_t;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mm_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr wins.
// Zero latency; no backpressure, callers sample win_vld when they can accept.
module mm_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_vld
);

  int cand;

  // Scan from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    win     = '0;
    win_idx = '0;
    win_vld = 1'b0;
    cand    = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % N_REQ;
      if (req[cand]) begin
        win       = '0;
        win[cand] = 1'b1;
        win_idx   = IDX_W'(cand);
        win_vld   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mm_job_arbiter.sv
// Round-robin owner arbitration for one MM core and its bridge BRAM; grant/start/done are registered, one cycle each.
// Backpressure: a grant is held until the owner releases; BRAM routing is combinational from state and grant.
module mm_job_arbiter
  import mm_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        go_i,
  input  logic [N_REQ-1:0]        release_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        done_o,
  input  logic [N_REQ*ADDR_W-1:0] host_addr_i,
  input  logic [N_REQ*DATA_W-1:0] host_din_i,
  input  logic [N_REQ-1:0]        host_we_i,
  input  logic [N_REQ-1:0]        host_en_i,
  output logic [DATA_W-1:0]       host_dout_o,
  output logic                    mm_start_o,
  input  logic                    mm_done_i,
  input  logic [ADDR_W-1:0]       mm_addr_i,
  input  logic [DATA_W-1:0]       mm_din_i,
  input  logic                    mm_we_i,
  input  logic                    mm_en_i,
  output logic [ADDR_W-1:0]       bram_addr_o,
  output logic [DATA_W-1:0]       bram_din_o,
  output logic                    bram_we_o,
  output logic                    bram_en_o,
  input  logic [DATA_W-1:0]       bram_dout_i,
  output logic [RUN_CNT_W-1:0]    run_cycles_o
);

  localparam int IDX_W = idx_w(N_REQ);

  arb_state_t           state;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     nxt_ptr;
  logic [N_REQ-1:0]     win;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_vld;
  logic [RUN_CNT_W-1:0] run_cnt;
  logic                 go_g;
  logic                 rel_g;

  logic [ADDR_W-1:0] h_addr [N_REQ];
  logic [DATA_W-1:0] h_din  [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_host
    assign h_addr[i] = host_addr_i[i*ADDR_W +: ADDR_W];
    assign h_din[i]  = host_din_i[i*DATA_W +: DATA_W];
  end

  mm_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req_i),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  assign nxt_ptr = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  assign go_g    = go_i[gnt_idx];
  assign rel_g   = release_i[gnt_idx];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt_idx      <= '0;
      gnt_o        <= '0;
      done_o       <= '0;
      mm_start_o   <= 1'b0;
      run_cnt      <= '0;
      run_cycles_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt_o   <= win;
            gnt_idx <= win_idx;
            ptr     <= nxt_ptr;
            state   <= HOST_LOAD;
          end
        end
        HOST_LOAD: begin
          if (go_g) begin
            mm_start_o <= 1'b1;
            state      <= START;
          end else if (rel_g) begin
            gnt_o <= '0;
            state <= IDLE;
          end
        end
        START: begin
          mm_start_o <= 1'b0;
          run_cnt    <= RUN_CNT_W'(1);
          state      <= RUN;
        end
        RUN: begin
          // The START cycle is already counted, so run_cnt is final when done arrives.
          if (mm_done_i) begin
            run_cycles_o <= run_cnt;
            done_o       <= gnt_o;
            state        <= HOST_READ;
          end else if (run_cnt != '1) begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        HOST_READ: begin
          if (rel_g) begin
            gnt_o  <= '0;
            done_o <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bram_addr_o = '0;
    bram_din_o  = '0;
    bram_we_o   = 1'b0;
    bram_en_o   = 1'b0;
    case (state)
      HOST_LOAD, HOST_READ: begin
        bram_addr_o = h_addr[gnt_idx];
        bram_din_o  = h_din[gnt_idx];
        bram_we_o   = host_we_i[gnt_idx];
        bram_en_o   = host_en_i[gnt_idx];
      end
      START, RUN: begin
        bram_addr_o = mm_addr_i;
        bram_din_o  = mm_din_i;
        bram_we_o   = mm_we_i;
        bram_en_o   = mm_en_i;
      end
      default: ;
    endcase
  end

  assign host_dout_o = bram_dout_i;

endmodule
